// File: rtl/uart_rx_if.sv
// Receive-side bundle of uart_rx: serial line in, framed byte and status out.
// The master side is the receiver; the slave side drives rx and consumes bytes.
interface uart_rx_if;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  rx,
    output po_data,
    output po_flag,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rx,
    input  po_data,
    input  po_flag,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: 3-flop line synchroniser, start-edge detect, mid-bit sampling.
// Each good frame updates po_data with a 1-cycle po_flag; a low stop bit pulses frame_err.
module uart_rx #(
  parameter int clk_frequence = 5_000_000,
  parameter int baud_rate     = 9600
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  localparam int CNT_BAUD_MAX = clk_frequence / baud_rate;
  localparam int CNT_HALF     = CNT_BAUD_MAX / 2;
  localparam int CNT_W        = $clog2(CNT_BAUD_MAX);

  localparam logic [CNT_W-1:0] BAUD_END = CNT_W'(CNT_BAUD_MAX - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CNT_HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_baud;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_s3;
  logic [7:0]       po_data;
  logic             po_flag;
  logic             frame_err;
  logic             rx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      state     <= IDLE;
      cnt_baud  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      po_data   <= '0;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_s1     <= bus.rx;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          cnt_baud <= '0;
          // Only a genuine high->low transition starts a frame; a held-low line never re-triggers.
          if (rx_s3 && !rx_s2) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt_baud == HALF_END) begin
            cnt_baud <= '0;
            if (!rx_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt_baud <= cnt_baud + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_baud == BAUD_END) begin
            cnt_baud <= '0;
            shift    <= {rx_s2, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            cnt_baud <= cnt_baud + CNT_W'(1);
          end
        end

        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
          if (cnt_baud == BAUD_END) begin
            cnt_baud <= '0;
            state    <= IDLE;
            rx_busy  <= 1'b0;
            if (rx_s2) begin
              po_data <= shift;
              po_flag <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_baud <= cnt_baud + CNT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          cnt_baud <= '0;
          rx_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.po_data   = po_data;
  assign bus.po_flag   = po_flag;
  assign bus.frame_err = frame_err;
  assign bus.rx_busy   = rx_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural serial transmitter queues expected pulses,
// per-instance monitors pop and compare whenever the receiver pulses po_flag or frame_err.
module tb_uart_rx;

  localparam int LAT0 = 2 + 260 + 9 * 520;  // default instance: 520 clk/bit
  localparam int LAT1 = 2 + 32 + 9 * 64;    // fast instance:    64 clk/bit

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] last_good [2];

  uart_rx_if b0 ();
  uart_rx_if b1 ();

  uart_rx #(.clk_frequence(5_000_000), .baud_rate(9600)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  uart_rx #(.clk_frequence(614_400), .baud_rate(9600)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(150_000 * 10);
    $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Behavioural transmitter: bit k begins at floor(k * period), period given in tenths of a clock.
  task automatic send(input int id, input logic [7:0] b, input bit stop, input int per_x10,
                      input bit expect_it, input bit timed);
    logic [9:0] frm;
    int   el;
    exp_t e;
    frm = {stop, b, 1'b0};
    el  = 0;
    if (expect_it) begin
      e.err  = !stop;
      e.data = stop ? b : last_good[id];
      e.t    = timed ? (cyc + 1 + (id == 0 ? LAT0 : LAT1)) : -1;
      if (stop) last_good[id] = b;
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
    for (int k = 0; k <= 10; k++) begin
      while (el < (k * per_x10) / 10) begin
        @(negedge clk);
        el++;
      end
      if (k < 10) begin
        if (id == 0) b0.rx = frm[k]; else b1.rx = frm[k];
      end
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q0.size() + q1.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b0.po_flag || b0.frame_err) begin
      chk("u0_flag_and_err_exclusive", {31'd0, b0.po_flag & b0.frame_err}, 0);
      chk("u0_pulse_expected", (q0.size() > 0) ? 1 : 0, 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("u0_kind_frame_err", {31'd0, b0.frame_err}, {31'd0, e.err});
        chk("u0_po_data", {24'd0, b0.po_data}, {24'd0, e.data});
        if (e.t >= 0) chk("u0_latency_cycle", cyc, e.t);
      end
    end
    if (b1.po_flag || b1.frame_err) begin
      chk("u1_pulse_expected", (q1.size() > 0) ? 1 : 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("u1_kind_frame_err", {31'd0, b1.frame_err}, {31'd0, e.err});
        chk("u1_po_data", {24'd0, b1.po_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    int e0;
    b0.rx = 1'b1;
    b1.rx = 1'b1;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    @(negedge clk);

    // Reset held while the line toggles: outputs stay at reset values.
    for (int i = 1; i <= 64; i++) begin
      b0.rx = 1'($urandom_range(0, 1));
      b1.rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i % 16 == 0)
        chk("reset_outputs", {20'd0, b0.po_data, b0.po_flag, b0.frame_err, b0.rx_busy, b1.rx_busy}, 0);
    end
    b0.rx = 1'b1;
    b1.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_busy_after_release", {31'd0, b0.rx_busy}, 0);

    // Single byte 0x55 with exact latency.
    e0 = cyc + 1;
    fork
      send(0, 8'h55, 1'b1, 5200, 1'b1, 1'b1);
      begin
        wait_cyc(e0 + 1);
        chk("busy_before_e0p2", {31'd0, b0.rx_busy}, 0);
        wait_cyc(e0 + 2);
        chk("busy_at_e0p2", {31'd0, b0.rx_busy}, 1);
      end
    join
    drain();

    // Back-to-back 0xA3 then 0x0F: second pulse exactly 5200 later via timed entries.
    send(0, 8'hA3, 1'b1, 5200, 1'b1, 1'b1);
    send(0, 8'h0F, 1'b1, 5200, 1'b1, 1'b1);
    drain();
    chk("po_data_holds", {24'd0, b0.po_data}, 32'h0F);

    // Glitch: 100 clk low is a false start.
    e0 = cyc + 1;
    b0.rx = 1'b0;
    repeat (100) @(negedge clk);
    b0.rx = 1'b1;
    wait_cyc(e0 + 261);
    chk("glitch_busy_before_abort", {31'd0, b0.rx_busy}, 1);
    wait_cyc(e0 + 262);
    chk("glitch_busy_after_abort", {31'd0, b0.rx_busy}, 0);
    repeat (600) @(negedge clk);

    // Framing error, long low hold, then recovery.
    send(0, 8'h12, 1'b1, 5200, 1'b1, 1'b1);
    send(0, 8'hFF, 1'b0, 5200, 1'b1, 1'b1);
    repeat (20 * 520) @(negedge clk);
    b0.rx = 1'b1;
    repeat (2 * 520) @(negedge clk);
    send(0, 8'h7E, 1'b1, 5200, 1'b1, 1'b1);
    drain();

    // Reset during bit 4 of 0xC3, held past the end of that frame.
    fork
      send(0, 8'hC3, 1'b1, 5200, 1'b0, 1'b0);
      begin
        repeat (4 * 520 + 260) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, b0.rx_busy}, 0);
        chk("async_reset_po_data", {24'd0, b0.po_data}, 0);
        repeat (6 * 520) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (50) @(negedge clk);
    send(0, 8'h3C, 1'b1, 5200, 1'b1, 1'b1);
    drain();

    // Random bytes at +2% and -2% baud into the 64 clk/bit instance.
    for (int i = 0; i < 24; i++)
      send(1, 8'($urandom), 1'b1, (i < 12) ? 653 : 627, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
